// File: rtl/task_seq_pkg.sv
// Shared definitions for the start/done sequencing handshake: state
// encoding and default task parameters used by sequencer and responders.
package task_seq_pkg;

  localparam int CNT_W_C          = 8;
  localparam int DEFAULT_CYCLES_C = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } task_state_e;

endpackage

// File: rtl/task_responder_if.sv
// Handshake bundle between a sequencer (master) and a task responder (slave).
interface task_responder_if #(
  parameter int CNT_W      = 8,
  parameter int DONE_CNT_W = 8
);

  logic                  start;
  logic [CNT_W-1:0]      cycles;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  logic [DONE_CNT_W-1:0] done_count;

  modport master (
    output start, cycles, stall,
    input  busy, done, overrun, done_count
  );

  modport slave (
    input  start, cycles, stall,
    output busy, done, overrun, done_count
  );

endinterface

// File: rtl/task_responder_latency_counter.sv
// Loadable down-counter that times one task; term flags the last RUN cycle.
module latency_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             term
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins, otherwise step down while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/task_responder.sv
// Worker end of the start/done handshake: accepts a start, runs for a
// programmable latency (stall freezes progress) and pulses done once.
module task_responder
  import task_seq_pkg::*;
#(
  parameter int CNT_W          = CNT_W_C,
  parameter int DEFAULT_CYCLES = DEFAULT_CYCLES_C,
  parameter int DONE_CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  task_responder_if.slave   bus
);

  task_state_e           state_q;
  task_state_e           state_d;
  logic                  overrun_q;
  logic                  overrun_d;
  logic [DONE_CNT_W-1:0] done_count_q;
  logic [DONE_CNT_W-1:0] done_count_d;

  logic                  load_s;
  logic                  cnt_en_s;
  logic                  term_s;
  logic [CNT_W-1:0]      load_val_s;

  // A zero request means "use the default latency".
  always_comb begin
    load_val_s = bus.cycles;
    if (bus.cycles == {CNT_W{1'b0}}) begin
      load_val_s = CNT_W'(DEFAULT_CYCLES);
    end else begin
      load_val_s = bus.cycles;
    end
  end

  assign cnt_en_s = (state_q == RUN) && !bus.stall;

  latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (cnt_en_s),
    .term     (term_s)
  );

  // Next-state, counter load, overrun and completion-count logic.
  always_comb begin
    state_d      = state_q;
    load_s       = 1'b0;
    overrun_d    = overrun_q;
    done_count_d = done_count_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A start while running is dropped but remembered.
        if (bus.start) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (!bus.stall && term_s) begin
          state_d      = DONE;
          done_count_d = done_count_q + {{(DONE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // The sequencer may chain the next task straight out of DONE.
        if (bus.start) begin
          load_s  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, sticky overrun and completion counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      overrun_q    <= 1'b0;
      done_count_q <= {DONE_CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      overrun_q    <= overrun_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.overrun    = overrun_q;
  assign bus.done_count = done_count_q;

endmodule

// File: tb/tb_task_responder.sv
// Directed self-checking bench for task_responder.
module tb_task_responder;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  task_responder_if #(.CNT_W(8), .DONE_CNT_W(8)) bus ();

  task_responder #(
    .CNT_W          (8),
    .DEFAULT_CYCLES (4),
    .DONE_CNT_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until done, counting edges since the accepting edge; -1 on timeout.
  task automatic wait_done(input int already, output int edges);
    edges = already;
    do begin
      step();
      edges++;
    end while (!bus.done && edges < 600);
    if (!bus.done) edges = -1;
  endtask

  int edges;
  int pulses;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.cycles   = 8'd0;
    bus.stall    = 1'b0;
    step();
    step();
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_ovr",  {31'd0, bus.overrun}, 32'd0);
    check_val("rst_cnt",  {24'd0, bus.done_count}, 32'd0);
    reset = 1'b0;
    step();

    // Default latency: cycles=0 -> 4 edges.
    bus.start = 1'b1; bus.cycles = 8'd0;
    step();
    bus.start = 1'b0;
    check_val("t1_busy", {31'd0, bus.busy}, 32'd1);
    check_val("t1_done_early", {31'd0, bus.done}, 32'd0);
    wait_done(0, edges);
    check_val("t1_lat", edges, 32'd4);
    check_val("t1_cnt", {24'd0, bus.done_count}, 32'd1);
    check_val("t1_ovr", {31'd0, bus.overrun}, 32'd0);
    step();
    check_val("t1_done_1cyc", {31'd0, bus.done}, 32'd0);
    check_val("t1_idle", {31'd0, bus.busy}, 32'd0);

    // cycles=10 with 3 stalled RUN cycles -> 13 edges.
    bus.start = 1'b1; bus.cycles = 8'd10;
    step();
    bus.start = 1'b0;
    step(); step();
    bus.stall = 1'b1;
    step(); step(); step();
    bus.stall = 1'b0;
    wait_done(5, edges);
    check_val("t2_lat", edges, 32'd13);
    step();
    check_val("t2_idle", {31'd0, bus.busy}, 32'd0);
    check_val("t2_cnt", {24'd0, bus.done_count}, 32'd2);

    // cycles=5, second start 2 cycles later is ignored and flags overrun.
    bus.start = 1'b1; bus.cycles = 8'd5;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.cycles = 8'd9;
    step();
    bus.start = 1'b0;
    check_val("t3_ovr_set", {31'd0, bus.overrun}, 32'd1);
    wait_done(2, edges);
    check_val("t3_lat", edges, 32'd5);
    step(); step(); step();
    check_val("t3_ovr_sticky", {31'd0, bus.overrun}, 32'd1);
    check_val("t3_idle", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset clears everything before the next edge.
    reset = 1'b1;
    #1;
    check_val("r2_ovr", {31'd0, bus.overrun}, 32'd0);
    check_val("r2_cnt", {24'd0, bus.done_count}, 32'd0);
    step();
    reset = 1'b0;

    // start held high with cycles=1: done every other cycle.
    bus.start = 1'b1; bus.cycles = 8'd1;
    step();
    check_val("t4_ovr0", {31'd0, bus.overrun}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t4_done_hi", {31'd0, bus.done}, 32'd1);
      check_val("t4_cnt", {24'd0, bus.done_count}, i + 1);
      step();
      check_val("t4_done_lo", {31'd0, bus.done}, 32'd0);
    end
    check_val("t4_ovr1", {31'd0, bus.overrun}, 32'd1);
    bus.start = 1'b0;
    step(); step();
    check_val("t4_idle", {31'd0, bus.busy}, 32'd0);

    // Reset 2 cycles into a cycles=8 task abandons it.
    bus.start = 1'b1; bus.cycles = 8'd8;
    step();
    bus.start = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    check_val("t5_busy", {31'd0, bus.busy}, 32'd0);
    check_val("t5_done", {31'd0, bus.done}, 32'd0);
    check_val("t5_ovr",  {31'd0, bus.overrun}, 32'd0);
    check_val("t5_cnt",  {24'd0, bus.done_count}, 32'd0);
    step();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) pulses++;
    end
    check_val("t5_no_done", pulses, 32'd0);
    bus.start = 1'b1; bus.cycles = 8'd3;
    step();
    bus.start = 1'b0;
    wait_done(0, edges);
    check_val("t5_new_lat", edges, 32'd3);
    check_val("t5_new_cnt", {24'd0, bus.done_count}, 32'd1);
    step();

    // Counter wrap: 255 more tasks bring it to 0.
    for (int i = 0; i < 255; i++) begin
      bus.start = 1'b1; bus.cycles = 8'd1;
      step();
      bus.start = 1'b0;
      step();
      if (i == 253) check_val("t6_cnt_255", {24'd0, bus.done_count}, 32'd255);
      step();
    end
    check_val("t6_wrap", {24'd0, bus.done_count}, 32'd0);

    // Maximum latency.
    bus.start = 1'b1; bus.cycles = 8'd255;
    step();
    bus.start = 1'b0;
    wait_done(0, edges);
    check_val("t6_lat255", edges, 32'd255);
    check_val("t6_cnt_after", {24'd0, bus.done_count}, 32'd1);
    step();
    check_val("t6_idle", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
